// File: rtl/serial_sub32.sv
// serial_sub32 -- bit-serial-by-nibble subtractor.
// Computes a - b as a + ~b + 1, one 4-bit carry-lookahead group per clock,
// carrying between groups through a register.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   begin one subtraction (accepted in IDLE or DONE)
//   a, b    minuend / subtrahend, captured on the accepting edge
//   busy    high while groups are being processed
//   done    one-cycle pulse, results valid
//   diff    a - b mod 2^WIDTH (changes only on the final-group edge)
//   borrow  unsigned borrow (a < b)
//   ovf     signed overflow of a - b
//   zero    diff == 0

// 4-bit carry-lookahead slice: per-bit propagate/generate, group carry-out.
module serial_sub32_cla4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] p, g, c;

    assign p = x ^ y;
    assign g = x & y;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign s = p ^ c;
endmodule

module serial_sub32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);
    localparam int GROUPS = WIDTH / 4;
    localparam int CW     = $clog2(GROUPS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_a, op_nb;      // op_nb holds ~b
    logic [WIDTH-1:0] work, work_nxt;   // partial result, filled group by group
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [CW+1:0]    base;             // bit offset of current group
    logic [3:0]       grp_sum;
    logic             grp_cout;
    logic             last_grp;
    logic             accept;

    assign base     = {cnt, 2'b00};
    assign last_grp = (cnt == CW'(GROUPS - 1));
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    serial_sub32_cla4 u_cla (
        .x    (op_a[base +: 4]),
        .y    (op_nb[base +: 4]),
        .cin  (carry),
        .s    (grp_sum),
        .cout (grp_cout)
    );

    always_comb begin
        work_nxt             = work;
        work_nxt[base +: 4]  = grp_sum;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept    = 1'b1;
                state_nxt = RUN;
            end
            RUN:  if (last_grp) state_nxt = DONE;
            // back-to-back start skips IDLE
            DONE: begin
                accept    = start;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_nb  <= '0;
            work   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_nb <= ~b;
            carry <= 1'b1;   // the +1 of two's-complement negation
            cnt   <= '0;
        end else if (state == RUN) begin
            work  <= work_nxt;
            carry <= grp_cout;
            cnt   <= cnt + 1'b1;
            if (last_grp) begin
                diff   <= work_nxt;
                borrow <= ~grp_cout;
                // signs of a and b differ <=> a[msb] == ~b[msb]
                ovf    <= (op_a[WIDTH-1] == op_nb[WIDTH-1]) &&
                          (work_nxt[WIDTH-1] != op_a[WIDTH-1]);
                zero   <= (work_nxt == '0);
            end
        end
    end
endmodule

// File: doc/serial_sub32.md
SERIAL_SUB32 -- requirements
Module: serial_sub32

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin one subtraction; sampled on rising clk.
REQ-005 a  input  WIDTH  minuend; sampled only on the edge that accepts start.
REQ-006 b  input  WIDTH  subtrahend; sampled only on the edge that accepts start.
REQ-007 busy  output  1  high while a subtraction is in progress.
REQ-008 done  output  1  one-cycle pulse marking a valid result.
REQ-009 diff  output  WIDTH  result a - b, modulo 2^WIDTH.
REQ-010 borrow  output  1  unsigned borrow: 1 when a < b as unsigned.
REQ-011 ovf  output  1  signed two's-complement overflow of a - b.
REQ-012 zero  output  1  1 when diff == 0.

Function
REQ-013 Datapath SHALL compute a + ~b + 1 one 4-bit group per cycle: one 4-bit carry-lookahead slice (per-bit p/g, group carry-out) plus a registered carry between groups.
REQ-014 FSM states SHALL be IDLE, RUN, DONE; encoding is free.
REQ-015 IDLE: start=1 -> latch a, ~b into operand registers; set carry register to 1; clear group counter to 0; go to RUN; busy=1 from the next cycle.
REQ-016 RUN: each edge processes group k (bits 4k+3:4k); writes 4 sum bits into the result register; stores group carry-out as carry for k+1; increments k.
REQ-017 RUN: on the edge processing group WIDTH/4-1, go to DONE; update diff/borrow/ovf/zero on that same edge.
REQ-018 Latency: start accepted on edge E -> done=1 and results valid in the cycle after edge E+WIDTH/4 (8 edges for WIDTH=32); busy high for exactly WIDTH/4 cycles.
REQ-019 DONE: lasts one cycle; done=1, busy=0; returns to IDLE unconditionally on the next edge.
REQ-020 start SHALL also be accepted in DONE (back-to-back); then the next state is RUN, not IDLE.
REQ-021 start while in RUN SHALL be ignored; operands and progress are not disturbed.
REQ-022 borrow = NOT(final group carry-out).
REQ-023 ovf = (a[WIDTH-1] != b[WIDTH-1]) AND (diff[WIDTH-1] != a[WIDTH-1]), using latched operands.
REQ-024 diff/borrow/ovf/zero SHALL hold their last values until the final group of the next operation is written.
REQ-025 diff bits SHALL be written group-by-group in an internal working register; the diff output SHALL change only on the final-group edge.
REQ-026 Changes on a/b after acceptance SHALL not affect the result.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, regardless of clk: busy=0, done=0, diff=0, borrow=0, ovf=0, zero=0, counter=0, carry=0.
REQ-028 Reset mid-RUN SHALL abandon the operation; no done pulse follows.
REQ-029 After rst_n rises, the first start accepted SHALL behave as in REQ-015.

Verification
REQ-030 a=0x00000005, b=0x00000003, start 1 cycle -> 8 busy cycles; then done=1 with diff=0x00000002, borrow=0, ovf=0, zero=0.
REQ-031 a=0x00000000, b=0x00000001 -> diff=0xFFFFFFFF, borrow=1, ovf=0, zero=0.
REQ-032 a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, borrow=0, ovf=1; then a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, borrow=1, ovf=1.
REQ-033 a=b=0x12345678 -> diff=0x00000000, zero=1, borrow=0; start re-asserted in the done cycle with a=0x10, b=0x01 -> busy next cycle; diff=0x0000000F after 8 more cycles.
REQ-034 Start a=0x100, b=0x1; pulse start with a=0xFFFFFFFF, b=0 on RUN cycle 3 -> ignored; result diff=0x000000FF, exactly one done pulse.
REQ-035 Start an operation; drop rst_n between clock edges on RUN cycle 4 -> busy and diff go to 0 with no clock edge required; no done pulse; a new start after release gives the correct result.
